// File: rtl/vram_write_arbiter_pkg.sv
// vram_write_arbiter_pkg: canvas geometry defaults and the arbiter state encoding
// shared by the VRAM write-port logic.
package vram_write_arbiter_pkg;

  localparam int H_LEN   = 200;
  localparam int V_LEN   = 150;
  localparam int DW      = 15;
  localparam int PIX_CNT = H_LEN * V_LEN;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vram_write_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. When both requesters are valid the one
// that did not win last time is granted; rr_last resets to 1 so requester 0
// wins the very first contest.
module rr_arb2 (
  input  logic       pclk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic rr_last;

  // grant is combinational so the requester sees ready in the same cycle
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // remember the winner of every handshake for the next contest
  always_ff @(posedge pclk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (grant[0]) begin
      rr_last <= 1'b0;
    end else if (grant[1]) begin
      rr_last <= 1'b1;
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: owns the canvas VRAM write port. Two requesters share it
// round-robin; a clear engine can take over to fill the whole canvas with one
// colour. Optionally every write is held off until vertical blank.
module vram_write_arbiter
  import vram_write_arbiter_pkg::*;
#(
  parameter int DW          = vram_write_arbiter_pkg::DW,
  parameter int H_LEN       = vram_write_arbiter_pkg::H_LEN,
  parameter int V_LEN       = vram_write_arbiter_pkg::V_LEN,
  parameter int VBLANK_ONLY = 0
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          ven,
  input  logic          clr_start,
  input  logic [11:0]   clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_addr,
  input  logic [11:0]   req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_addr,
  input  logic [11:0]   req1_data,
  output logic          req1_ready,
  output logic          we,
  output logic [DW-1:0] waddr,
  output logic [11:0]   wdata,
  output logic          oor_drop
);

  localparam int            PIX_TOTAL = H_LEN * V_LEN;
  localparam logic [DW:0]   PIX_LIMIT = (DW+1)'(PIX_TOTAL);
  localparam logic [DW-1:0] LAST_ADDR = DW'(PIX_TOTAL - 1);

  arb_state_t    state;
  logic [DW-1:0] clr_cnt;
  logic [11:0]   clr_col;
  logic          clr_last;
  logic          gate;
  logic          arb_en;
  logic [1:0]    grant;
  logic [DW-1:0] sel_addr;
  logic [11:0]   sel_data;
  logic          sel_in_range;

  // write gating, arbitration enable and selection of the granted request;
  // a clear request in IDLE takes the cycle away from both requesters
  always_comb begin
    gate         = (VBLANK_ONLY == 0) || !ven;
    arb_en       = (state == IDLE) && !clr_start && gate;
    sel_addr     = grant[1] ? req1_addr : req0_addr;
    sel_data     = grant[1] ? req1_data : req0_data;
    sel_in_range = ({1'b0, sel_addr} < PIX_LIMIT);
  end

  rr_arb2 u_rr_arb2 (
    .pclk   (pclk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .enable (arb_en),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // clear FSM plus the registered VRAM write port; clr_last marks that the
  // final canvas address has gone out so clr_done lands one cycle after it
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      oor_drop <= 1'b0;
      clr_cnt  <= '0;
      clr_col  <= '0;
      clr_last <= 1'b0;
    end else begin
      we       <= 1'b0;
      clr_done <= 1'b0;
      oor_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_col  <= clr_color;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
            clr_last <= 1'b0;
          end else if (|grant) begin
            if (sel_in_range) begin
              we    <= 1'b1;
              waddr <= sel_addr;
              wdata <= sel_data;
            end else begin
              oor_drop <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (clr_last) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
            clr_last <= 1'b0;
          end else if (gate) begin
            we    <= 1'b1;
            waddr <= clr_cnt;
            wdata <= clr_col;
            if (clr_cnt == LAST_ADDR) begin
              clr_last <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: directed scenarios plus a randomized run against a
// behavioural model of the write-port rules on a 4x3 canvas.
module tb_vram_write_arbiter;

  localparam int DW    = 4;
  localparam int H_LEN = 4;
  localparam int V_LEN = 3;
  localparam int PIX   = H_LEN * V_LEN;

  logic          pclk = 1'b0;
  logic          rst;
  logic          ven;
  logic          clr_start;
  logic [11:0]   clr_color;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_addr, req1_addr;
  logic [11:0]   req0_data, req1_data;

  logic          clr_busy, clr_done, req0_ready, req1_ready, we, oor_drop;
  logic [DW-1:0] waddr;
  logic [11:0]   wdata;

  logic          f_clr_busy, f_clr_done, f_req0_ready, f_req1_ready, f_we, f_oor_drop;
  logic [DW-1:0] f_waddr;
  logic [11:0]   f_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  vram_write_arbiter #(.DW(DW), .H_LEN(H_LEN), .V_LEN(V_LEN), .VBLANK_ONLY(1)) dut (
    .pclk(pclk), .rst(rst), .ven(ven), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .oor_drop(oor_drop)
  );

  vram_write_arbiter #(.DW(DW), .H_LEN(H_LEN), .V_LEN(V_LEN), .VBLANK_ONLY(0)) dut_free (
    .pclk(pclk), .rst(rst), .ven(ven), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(f_clr_busy), .clr_done(f_clr_done),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(f_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(f_req1_ready),
    .we(f_we), .waddr(f_waddr), .wdata(f_wdata), .oor_drop(f_oor_drop)
  );

  // hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    ven        = 1'b0;
    clr_start  = 1'b0;
    clr_color  = 12'h000;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = 12'h000;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = 12'h000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({we, waddr, wdata, clr_busy, clr_done, oor_drop} !== 20'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_regs: got we=%b waddr=%h wdata=%h busy=%b done=%b oor=%b, expected all zero",
               we, waddr, wdata, clr_busy, clr_done, oor_drop);
    end
    n_cmp++;
    if ({f_we, f_waddr, f_wdata, f_clr_busy, f_clr_done, f_oor_drop} !== 20'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_regs_free: got we=%b waddr=%h wdata=%h, expected all zero",
               f_we, f_waddr, f_wdata);
    end
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL reset_first_contest: got ready=%b, expected 01", {req1_ready, req0_ready});
    end
    idle_inputs();
  endtask

  task automatic test_single_writer();
    do_reset();
    req0_valid = 1'b1;
    req0_addr  = 4'd5;
    req0_data  = 12'hF00;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL single_ready: got %b, expected 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b1, 4'd5, 12'hF00}) begin
      n_bad++;
      $display("[TB] FAIL single_write: got we=%b waddr=%h wdata=%h, expected 1/5/f00", we, waddr, wdata);
    end
    tick();
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b0, 4'd5, 12'hF00}) begin
      n_bad++;
      $display("[TB] FAIL single_hold: got we=%b waddr=%h wdata=%h, expected 0/5/f00", we, waddr, wdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0]    exp_rdy;
    logic [DW-1:0] exp_a;
    logic [11:0]   exp_d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1;
      req0_addr  = 4'd1;
      req0_data  = 12'h100 + 12'(k);
      req1_valid = 1'b1;
      req1_addr  = 4'd2;
      req1_data  = 12'h200 + 12'(k);
      exp_rdy    = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a      = (k % 2 == 0) ? 4'd1 : 4'd2;
      exp_d      = (k % 2 == 0) ? req0_data : req1_data;
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        n_bad++;
        $display("[TB] FAIL contention_grant[%0d]: got %b, expected %b", k, {req1_ready, req0_ready}, exp_rdy);
      end
      tick();
      n_cmp++;
      if ({we, waddr, wdata} !== {1'b1, exp_a, exp_d}) begin
        n_bad++;
        $display("[TB] FAIL contention_write[%0d]: got we=%b waddr=%h wdata=%h, expected 1/%h/%h",
                 k, we, waddr, wdata, exp_a, exp_d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    logic          exp_we;
    logic [DW-1:0] exp_a;
    do_reset();
    clr_start = 1'b1;
    clr_color = 12'h0A0;
    tick();
    clr_start  = 1'b0;
    clr_color  = 12'hFFF;
    req0_valid = 1'b1;
    req0_addr  = 4'd3;
    req0_data  = 12'h123;
    for (int c = 1; c <= 14; c++) begin
      exp_we = (c >= 2) && (c <= 13);
      exp_a  = 4'(c - 2);
      n_cmp++;
      if ({we, clr_busy, clr_done} !== {exp_we, (c <= 13), (c == 14)}) begin
        n_bad++;
        $display("[TB] FAIL clear_flags[%0d]: got we=%b busy=%b done=%b, expected %b/%b/%b",
                 c, we, clr_busy, clr_done, exp_we, (c <= 13), (c == 14));
      end
      if (exp_we) begin
        n_cmp++;
        if ({waddr, wdata} !== {exp_a, 12'h0A0}) begin
          n_bad++;
          $display("[TB] FAIL clear_write[%0d]: got waddr=%h wdata=%h, expected %h/0a0", c, waddr, wdata, exp_a);
        end
      end
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== {1'b0, (c == 14)}) begin
        n_bad++;
        $display("[TB] FAIL clear_ready[%0d]: got %b, expected 0%b", c, {req1_ready, req0_ready}, (c == 14));
      end
      tick();
    end
    req0_valid = 1'b0;
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b1, 4'd3, 12'h123}) begin
      n_bad++;
      $display("[TB] FAIL clear_then_req: got we=%b waddr=%h wdata=%h, expected 1/3/123", we, waddr, wdata);
    end
  endtask

  task automatic test_priority();
    bit seen_done;
    do_reset();
    clr_start  = 1'b1;
    clr_color  = 12'h00F;
    req0_valid = 1'b1;
    req0_addr  = 4'd0;
    req0_data  = 12'h555;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL priority_ready: got %b, expected 00", {req1_ready, req0_ready});
    end
    tick();
    clr_start  = 1'b0;
    req0_valid = 1'b0;
    n_cmp++;
    if ({clr_busy, we} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL priority_clear_begins: got busy=%b we=%b, expected 1/0", clr_busy, we);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      tick();
      if (clr_done) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL priority_clear_done: got done_seen=%b, expected 1 within 30 cycles", seen_done);
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] addrs [3];
    addrs[0] = 4'd12;
    addrs[1] = 4'd15;
    addrs[2] = 4'd11;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1;
      req1_addr  = addrs[k];
      req1_data  = 12'hABC;
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
        n_bad++;
        $display("[TB] FAIL oor_ready[%0d]: got %b, expected 10", k, {req1_ready, req0_ready});
      end
      tick();
      n_cmp++;
      if ({we, oor_drop} !== {(addrs[k] < 4'd12), (addrs[k] >= 4'd12)}) begin
        n_bad++;
        $display("[TB] FAIL oor_result[%0d]: addr=%0d got we=%b oor=%b", k, addrs[k], we, oor_drop);
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if ({we, oor_drop} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL oor_pulse_end: got we=%b oor=%b, expected 0/0", we, oor_drop);
    end
  endtask

  task automatic test_vblank();
    logic    prev_ven;
    bit      seen_done;
    int      nwr;
    do_reset();
    ven        = 1'b1;
    req0_valid = 1'b1;
    req0_addr  = 4'd2;
    req0_data  = 12'h2C2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({req0_ready, we} !== 2'b00) begin
        n_bad++;
        $display("[TB] FAIL vblank_hold[%0d]: got ready=%b we=%b, expected 0/0", i, req0_ready, we);
      end
      tick();
    end
    ven = 1'b0;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL vblank_release: got ready=%b, expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b1, 4'd2, 12'h2C2}) begin
      n_bad++;
      $display("[TB] FAIL vblank_write: got we=%b waddr=%h wdata=%h, expected 1/2/2c2", we, waddr, wdata);
    end
    ven       = 1'b1;
    clr_start = 1'b1;
    clr_color = 12'h0F0;
    prev_ven  = 1'b1;
    tick();
    clr_start = 1'b0;
    n_cmp++;
    if (clr_busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL vblank_clear_pending: got busy=%b, expected 1", clr_busy);
    end
    nwr       = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      if (we) begin
        n_cmp++;
        if ({waddr, wdata, prev_ven} !== {4'(nwr), 12'h0F0, 1'b0}) begin
          n_bad++;
          $display("[TB] FAIL vblank_clear_write[%0d]: got waddr=%h wdata=%h prior_ven=%b, expected %h/0f0/0",
                   nwr, waddr, wdata, prev_ven, 4'(nwr));
        end
        nwr++;
      end
      if (clr_done) seen_done = 1'b1;
      ven      = 1'($urandom_range(0, 1));
      prev_ven = ven;
      tick();
    end
    n_cmp++;
    if ({seen_done, 32'(nwr)} !== {1'b1, 32'(PIX)}) begin
      n_bad++;
      $display("[TB] FAIL vblank_clear_total: got done=%b writes=%0d, expected 1/%0d", seen_done, nwr, PIX);
    end
    idle_inputs();
  endtask

  task automatic test_free_running();
    do_reset();
    ven        = 1'b1;
    req0_valid = 1'b1;
    req0_addr  = 4'd4;
    req0_data  = 12'h444;
    #1;
    n_cmp++;
    if ({f_req0_ready, req0_ready} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL free_ready: got free=%b gated=%b, expected 1/0", f_req0_ready, req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if ({f_we, f_waddr, f_wdata, we} !== {1'b1, 4'd4, 12'h444, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL free_write: got free we=%b waddr=%h wdata=%h gated we=%b, expected 1/4/444/0",
               f_we, f_waddr, f_wdata, we);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    bit hit;
    bit stray;
    do_reset();
    clr_start = 1'b1;
    clr_color = 12'h333;
    tick();
    clr_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (we && waddr == 4'd6) hit = 1'b1;
      else tick();
    end
    n_cmp++;
    if (hit !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midclear_reach6: got hit=%b, expected 1 within 30 cycles", hit);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({we, clr_busy, clr_done} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL midclear_abort: got we=%b busy=%b done=%b, expected 0/0/0", we, clr_busy, clr_done);
    end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (we || clr_done || clr_busy) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midclear_quiet: got activity=%b after abort, expected 0", stray);
    end
    req0_valid = 1'b1;
    req0_addr  = 4'd7;
    req0_data  = 12'h777;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midclear_req_ready: got %b, expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b1, 4'd7, 12'h777}) begin
      n_bad++;
      $display("[TB] FAIL midclear_req_write: got we=%b waddr=%h wdata=%h, expected 1/7/777", we, waddr, wdata);
    end
  endtask

  // randomized traffic against a rule-level model of the gated instance
  task automatic test_random();
    int            clr_pos;
    int            rrl;
    int            w;
    logic [11:0]   col;
    logic          e_we, e_busy, e_done, e_oor;
    logic [DW-1:0] e_wa, a;
    logic [11:0]   e_wd, d;
    logic [1:0]    e_rdy;
    do_reset();
    clr_pos = -1;
    rrl     = 1;
    col     = 12'h000;
    e_we    = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_oor   = 1'b0;
    e_wa    = '0;
    e_wd    = 12'h000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++;
      if ({we, waddr, wdata, clr_busy, clr_done, oor_drop} !== {e_we, e_wa, e_wd, e_busy, e_done, e_oor}) begin
        n_bad++;
        $display("[TB] FAIL random_regs[%0d]: got we=%b wa=%h wd=%h busy=%b done=%b oor=%b, expected %b/%h/%h/%b/%b/%b",
                 cyc, we, waddr, wdata, clr_busy, clr_done, oor_drop, e_we, e_wa, e_wd, e_busy, e_done, e_oor);
      end
      ven        = ($urandom_range(0, 3) == 0);
      clr_start  = ($urandom_range(0, 24) == 0);
      clr_color  = 12'($urandom);
      req0_valid = 1'($urandom_range(0, 1));
      req0_addr  = 4'($urandom);
      req0_data  = 12'($urandom);
      req1_valid = 1'($urandom_range(0, 1));
      req1_addr  = 4'($urandom);
      req1_data  = 12'($urandom);
      e_rdy  = 2'b00;
      e_we   = 1'b0;
      e_done = 1'b0;
      e_oor  = 1'b0;
      if (clr_pos < 0) begin
        if (clr_start) begin
          clr_pos = 0;
          col     = clr_color;
          e_busy  = 1'b1;
        end else if (!ven && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) w = 1 - rrl;
          else w = req0_valid ? 0 : 1;
          rrl      = w;
          e_rdy[w] = 1'b1;
          a = (w == 1) ? req1_addr : req0_addr;
          d = (w == 1) ? req1_data : req0_data;
          if (int'(a) < PIX) begin
            e_we = 1'b1;
            e_wa = a;
            e_wd = d;
          end else begin
            e_oor = 1'b1;
          end
        end
      end else if (clr_pos == PIX) begin
        clr_pos = -1;
        e_busy  = 1'b0;
        e_done  = 1'b1;
      end else if (!ven) begin
        e_we    = 1'b1;
        e_wa    = 4'(clr_pos);
        e_wd    = col;
        clr_pos = clr_pos + 1;
      end
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== e_rdy) begin
        n_bad++;
        $display("[TB] FAIL random_ready[%0d]: got %b, expected %b", cyc, {req1_ready, req0_ready}, e_rdy);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_writer();
    test_contention();
    test_clear();
    test_priority();
    test_out_of_range();
    test_vblank();
    test_free_running();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
